// File: rtl/cnn_weight_pkg.sv
// Shared types and elaboration-time helpers for the 1x1 convolution weight streamer.
package cnn_weight_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READY  = 2'd1,
        STREAM = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam int GAP_CNT_W = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Counters always keep at least one bit so single-entry sets still elaborate.
    function automatic int ptr_width(input int depth);
        int w;
        w = clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int calc_depth(input int c_out, input int c_in, input int k);
        return c_out * c_in * k * k;
    endfunction

endpackage

// File: rtl/cnn_weight_ram.sv
// Simple dual-port weight store: synchronous write, one-cycle registered read.
module cnn_weight_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8192,
    parameter int ADDR_W     = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port; output register holds its value between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/cnn_weight_streamer_1x1.sv
// Loads a full 1x1 conv weight set once and replays it as a valid-qualified stream per start.
// Optional checksum of each stream is enabled with CNN_WEIGHT_STREAMER_CHECKSUM_EN.
import cnn_weight_pkg::*;

module cnn_weight_streamer_1x1 #(
    parameter int DATA_WIDTH      = 16,
    parameter int CHANNEL_NUM_IN  = 64,
    parameter int CHANNEL_NUM_OUT = 128,
    parameter int KERNEL          = 1,
    parameter int STREAM_GAP      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  loaded,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  valid_weight_out,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           checksum
);

    localparam int DEPTH = calc_depth(CHANNEL_NUM_OUT, CHANNEL_NUM_IN, KERNEL);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int GROUP = CHANNEL_NUM_IN * KERNEL * KERNEL;
    localparam int GRP_W = ptr_width(GROUP);

    state_t               state_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_cnt_r;
    logic [GRP_W-1:0]     grp_cnt_r;
    logic [GAP_CNT_W-1:0] gap_cnt_r;
    logic                 drain_r;
    logic                 loaded_r;
    logic                 busy_r;
    logic                 valid_r;
    logic                 done_r;
    logic                 ram_we_s;
    logic                 rd_en_s;

    // RAM strobes: writes only while loading, reads while streaming until the last address is issued.
    always_comb begin
        ram_we_s = 1'b0;
        rd_en_s  = 1'b0;
        if (state_r == IDLE) begin
            ram_we_s = load_valid;
        end else begin
            ram_we_s = 1'b0;
        end
        if ((state_r == STREAM) && !drain_r) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Control FSM; drain_r marks the cycle the final word is on the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_cnt_r  <= {PTR_W{1'b0}};
            grp_cnt_r <= {GRP_W{1'b0}};
            gap_cnt_r <= {GAP_CNT_W{1'b0}};
            drain_r   <= 1'b0;
            loaded_r  <= 1'b0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            valid_r <= rd_en_s;
            done_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load_valid) begin
                        if (wr_ptr_r == PTR_W'(DEPTH - 1)) begin
                            wr_ptr_r <= {PTR_W{1'b0}};
                            loaded_r <= 1'b1;
                            state_r  <= READY;
                        end else begin
                            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                        end
                    end
                end
                READY: begin
                    if (start) begin
                        state_r   <= STREAM;
                        busy_r    <= 1'b1;
                        rd_cnt_r  <= {PTR_W{1'b0}};
                        grp_cnt_r <= {GRP_W{1'b0}};
                        drain_r   <= 1'b0;
                    end
                end
                STREAM: begin
                    if (drain_r) begin
                        drain_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= READY;
                    end else if (rd_cnt_r == PTR_W'(DEPTH - 1)) begin
                        // Last address issued: no gap after the final group.
                        rd_cnt_r <= {PTR_W{1'b0}};
                        drain_r  <= 1'b1;
                    end else begin
                        rd_cnt_r <= rd_cnt_r + PTR_W'(1);
                        if (grp_cnt_r == GRP_W'(GROUP - 1)) begin
                            grp_cnt_r <= {GRP_W{1'b0}};
                            if (STREAM_GAP != 0) begin
                                gap_cnt_r <= {GAP_CNT_W{1'b0}};
                                state_r   <= GAP;
                            end
                        end else begin
                            grp_cnt_r <= grp_cnt_r + GRP_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GAP_CNT_W'(STREAM_GAP - 1)) begin
                        state_r <= STREAM;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    cnn_weight_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (ram_we_s),
        .wr_addr (wr_ptr_r),
        .wr_data (load_data),
        .rd_en   (rd_en_s),
        .rd_addr (rd_cnt_r),
        .rd_data (weight_out)
    );

`ifdef CNN_WEIGHT_STREAMER_CHECKSUM_EN
    logic [31:0] acc_r;
    logic [31:0] checksum_r;

    // Running sum of streamed words; the final sum is published so it is visible with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r      <= 32'd0;
            checksum_r <= 32'd0;
        end else begin
            if ((state_r == READY) && start) begin
                acc_r <= 32'd0;
            end else if (valid_r) begin
                acc_r <= acc_r + 32'(weight_out);
            end
            if ((state_r == STREAM) && drain_r) begin
                checksum_r <= acc_r + 32'(weight_out);
            end
        end
    end

    assign checksum = checksum_r;
`else
    assign checksum = 32'd0;
`endif

    assign loaded           = loaded_r;
    assign busy             = busy_r;
    assign valid_weight_out = valid_r;
    assign done             = done_r;

endmodule
